// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit: FSM state encoding,
// next-PC select encodings and the default reset/trap vectors.
package pc_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  // Next-PC select encodings (2'b11 aliases PC+4)
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;

  // Default vectors
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // A target is misaligned when it is not on a 32-bit word boundary
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction fetch bus: request/grant handshake plus response channel.
// The fetch unit is the master; the instruction memory is the slave.
interface pc_fetch_unit_if;

  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt;
  logic        IRValid;
  logic [31:0] IRData;

  modport master (
    output IReq,
    output IAddr,
    input  IGnt,
    input  IRValid,
    input  IRData
  );

  modport slave (
    input  IReq,
    input  IAddr,
    output IGnt,
    output IRValid,
    output IRData
  );

endinterface

// File: rtl/pc_fetch_unit_next_sel.sv
// Combinational next-PC selection: PC+4, branch/JAL target or JALR ALU
// result (bit 0 cleared), followed by the alignment policy.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned target traps
// to TRAP_VECTOR instead of being silently word-aligned).
module pc_next_sel
  import pc_pkg::*;
`ifdef PC_MISALIGN_TRAP_EN
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
)
`endif
(
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        take_trap,
  output logic [31:0] bad_target,
`endif
  output logic [31:0] next_pc
);

  logic [31:0] sel_target;

  // Pick the raw target, then apply the alignment policy
  always_comb begin
    case (pc_src)
      PCSRC_TARGET: sel_target = pc_target;
      // JALR clears bit 0 before anything looks at alignment
      PCSRC_ALU:    sel_target = alu_result & ~32'h1;
      default:      sel_target = pc_plus4;
    endcase

`ifdef PC_MISALIGN_TRAP_EN
    take_trap  = is_misaligned(sel_target);
    bad_target = sel_target;
    next_pc    = take_trap ? TRAP_VECTOR : sel_target;
`else
    // Without the trap, targets are forced onto a word boundary
    next_pc    = sel_target & ~32'h3;
`endif
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch sequencer. Fetches the word at PC over
// the request/grant/response bus, presents it for one EXEC cycle, then
// loads the selected next PC.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned-target trap,
// MisalignTrap pulse and BadAddr capture; tied off when undefined).
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pc_fetch_unit_if.master         ibus,
  input  logic [1:0]              PCSrc,
  input  logic [31:0]             PCTarget,
  input  logic [31:0]             ALUResult,
  output logic [31:0]             Instr,
  output logic                    InstrValid,
  output logic [31:0]             PC,
  output logic [31:0]             PCPlus4,
  output logic                    MisalignTrap,
  output logic [31:0]             BadAddr
);

  fetch_state_e state_reg;
  fetch_state_e state_next;

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr_reg;

  logic        ireq;
  logic        instr_valid;
  logic        latch_instr;
  logic        load_pc;

  assign pc_plus4 = pc_reg + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  logic        take_trap;
  logic [31:0] bad_target;
  logic        trap_reg;
  logic [31:0] bad_addr_reg;

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_sel (
    .pc_plus4   (pc_plus4),
    .pc_src     (PCSrc),
    .pc_target  (PCTarget),
    .alu_result (ALUResult),
    .take_trap  (take_trap),
    .bad_target (bad_target),
    .next_pc    (pc_next)
  );
`else
  pc_next_sel u_next_sel (
    .pc_plus4   (pc_plus4),
    .pc_src     (PCSrc),
    .pc_target  (PCTarget),
    .alu_result (ALUResult),
    .next_pc    (pc_next)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: grant moves to WAIT, a response moves to EXEC
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (ibus.IGnt) begin
          state_next = ibus.IRValid ? EXEC : WAIT;
        end
      end
      WAIT: begin
        if (ibus.IRValid) begin
          state_next = EXEC;
        end
      end
      EXEC:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Per-state outputs and register enables
  always_comb begin
    ireq        = 1'b0;
    instr_valid = 1'b0;
    latch_instr = 1'b0;
    load_pc     = 1'b0;
    case (state_reg)
      FETCH: begin
        ireq        = 1'b1;
        // A response only counts in FETCH when it rides with the grant
        latch_instr = ibus.IGnt & ibus.IRValid;
      end
      WAIT: begin
        latch_instr = ibus.IRValid;
      end
      EXEC: begin
        instr_valid = 1'b1;
        load_pc     = 1'b1;
      end
      default: begin
        ireq = 1'b0;
      end
    endcase
  end

  // Program counter: loaded once per instruction at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_VECTOR;
    end else if (load_pc) begin
      pc_reg <= pc_next;
    end
  end

  // Instruction latch: changes only when a response is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= 32'h0;
    end else if (latch_instr) begin
      instr_reg <= ibus.IRData;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Trap pulse lands in the FETCH cycle after the faulting EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_reg     <= 1'b0;
      bad_addr_reg <= 32'h0;
    end else begin
      trap_reg <= load_pc & take_trap;
      if (load_pc && take_trap) begin
        bad_addr_reg <= bad_target;
      end
    end
  end

  assign MisalignTrap = trap_reg;
  assign BadAddr      = bad_addr_reg;
`else
  assign MisalignTrap = 1'b0;
  assign BadAddr      = 32'h0;
`endif

  // Request is suppressed while reset is held so nothing is issued early
  assign ibus.IReq  = ireq & rst_n;
  assign ibus.IAddr = pc_reg;

  assign Instr      = instr_reg;
  assign InstrValid = instr_valid;
  assign PC         = pc_reg;
  assign PCPlus4    = pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, reset
// corner case, then randomized instructions against a reference model.
module tb_pc_fetch_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignTrap;
  logic [31:0] BadAddr;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ibus         (bus),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .ALUResult    (ALUResult),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .MisalignTrap (MisalignTrap),
    .BadAddr      (BadAddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] model_pc;
  logic [31:0] last_instr;
  logic        exp_trap;
  logic [31:0] exp_bad;

  typedef struct {
    int          gw;
    int          rw;
    logic [31:0] data;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic [31:0] exp_next;
    logic        exp_trap;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, using plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] tgt, input logic [31:0] alu,
                                           output logic trap);
    logic [31:0] t;
    if (src == 2'b01)      t = tgt;
    else if (src == 2'b10) t = alu - (alu % 2);
    else                   t = pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
    trap = (t % 4) != 0;
    return trap ? 32'h0000_0100 : t;
`else
    trap = 1'b0;
    return t - (t % 4);
`endif
  endfunction

  // One instruction: gw cycles without grant, grant, rw WAIT cycles
  // (0 = response with the grant), then EXEC where the next PC is chosen
  task automatic do_instr(input int gw, input int rw, input logic [31:0] data,
                          input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    for (int k = 0; k <= gw; k++) begin
      @(negedge clk);
      check("fetch_IReq", {31'b0, bus.IReq}, 32'd1);
      check("fetch_IAddr", bus.IAddr, model_pc);
      check("fetch_InstrValid", {31'b0, InstrValid}, 32'd0);
      check("fetch_Instr_hold", Instr, last_instr);
      check("trap_pulse", {31'b0, MisalignTrap}, (k == 0) ? {31'b0, exp_trap} : 32'd0);
      if (k == 0) check("BadAddr", BadAddr, exp_bad);
      bus.IGnt    = (k == gw);
      bus.IRValid = (k == gw) ? (rw == 0) : 1'($urandom_range(0, 1));
      bus.IRData  = ((k == gw) && (rw == 0)) ? data : $urandom;
    end
    exp_trap = 1'b0;
    for (int j = 0; j < rw; j++) begin
      @(negedge clk);
      check("wait_IReq", {31'b0, bus.IReq}, 32'd0);
      check("wait_InstrValid", {31'b0, InstrValid}, 32'd0);
      check("wait_Instr_hold", Instr, last_instr);
      bus.IGnt    = 1'b0;
      bus.IRValid = (j == rw - 1);
      bus.IRData  = (j == rw - 1) ? data : $urandom;
    end
    @(negedge clk);
    check("exec_InstrValid", {31'b0, InstrValid}, 32'd1);
    check("exec_Instr", Instr, data);
    check("exec_PC", PC, model_pc);
    check("exec_PCPlus4", PCPlus4, model_pc + 32'd4);
    check("exec_IReq", {31'b0, bus.IReq}, 32'd0);
    bus.IGnt    = 1'b0;
    bus.IRValid = 1'b0;
    PCSrc       = src;
    PCTarget    = tgt;
    ALUResult   = alu;
    last_instr  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic        t;
    logic [1:0]  rsrc;
    logic [31:0] rtgt;
    logic [31:0] ralu;
    logic [31:0] rnext;

    // Directed table: {gw, rw, data, src, target, alu, next, trap, bad}
    vecs[0] = '{0, 0, 32'h0050_0093, 2'b00, 32'h0,         32'h0,   32'h0000_0004, 1'b0, 32'h0};
    vecs[1] = '{3, 1, 32'h0000_0013, 2'b01, 32'h10,        32'h0,   32'h0000_0010, 1'b0, 32'h0};
    vecs[2] = '{0, 1, 32'h1234_5678, 2'b01, 32'h40,        32'h0,   32'h0000_0040, 1'b0, 32'h0};
    vecs[3] = '{1, 2, 32'h8765_4321, 2'b10, 32'h0,         32'h81,  32'h0000_0080, 1'b0, 32'h0};
    vecs[4] = '{0, 0, 32'hAAAA_5555, 2'b01, 32'hFFFF_FFFC, 32'h0,   32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[5] = '{0, 1, 32'h5555_AAAA, 2'b00, 32'h0,         32'h0,   32'h0000_0000, 1'b0, 32'h0};
    vecs[6] = '{2, 0, 32'h0000_0001, 2'b11, 32'h0,         32'h0,   32'h0000_0004, 1'b0, 32'h0};
`ifdef PC_MISALIGN_TRAP_EN
    vecs[7] = '{0, 1, 32'hCAFE_0001, 2'b01, 32'h42,        32'h0,   32'h0000_0100, 1'b1, 32'h42};
    vecs[8] = '{0, 0, 32'hCAFE_0002, 2'b00, 32'h0,         32'h0,   32'h0000_0104, 1'b0, 32'h42};
    vecs[9] = '{1, 1, 32'hCAFE_0003, 2'b10, 32'h0,         32'h203, 32'h0000_0100, 1'b1, 32'h202};
`else
    vecs[7] = '{0, 1, 32'hCAFE_0001, 2'b01, 32'h42,        32'h0,   32'h0000_0040, 1'b0, 32'h0};
    vecs[8] = '{0, 0, 32'hCAFE_0002, 2'b00, 32'h0,         32'h0,   32'h0000_0044, 1'b0, 32'h0};
    vecs[9] = '{1, 1, 32'hCAFE_0003, 2'b10, 32'h0,         32'h203, 32'h0000_0200, 1'b0, 32'h0};
`endif

    rst_n       = 1'b0;
    bus.IGnt    = 1'b0;
    bus.IRValid = 1'b0;
    bus.IRData  = 32'h0;
    PCSrc       = 2'b00;
    PCTarget    = 32'h0;
    ALUResult   = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_IReq", {31'b0, bus.IReq}, 32'd0);
    check("rst_PC", PC, 32'h0);
    check("rst_Instr", Instr, 32'h0);
    check("rst_InstrValid", {31'b0, InstrValid}, 32'd0);
    check("rst_MisalignTrap", {31'b0, MisalignTrap}, 32'd0);
    check("rst_BadAddr", BadAddr, 32'h0);
    rst_n = 1'b1;

    model_pc   = 32'h0;
    last_instr = 32'h0;
    exp_trap   = 1'b0;
    exp_bad    = 32'h0;

    foreach (vecs[i]) begin
      do_instr(vecs[i].gw, vecs[i].rw, vecs[i].data, vecs[i].src, vecs[i].tgt, vecs[i].alu);
      $display("vec %0d: pc=%h src=%b next=%h trap=%0b", i, model_pc, vecs[i].src,
               vecs[i].exp_next, vecs[i].exp_trap);
      model_pc = vecs[i].exp_next;
      exp_trap = vecs[i].exp_trap;
      exp_bad  = vecs[i].exp_bad;
    end

    // Reset while waiting for a response, then a stale response right after
    @(negedge clk);
    check("rstseq_IAddr", bus.IAddr, model_pc);
    check("rstseq_trap", {31'b0, MisalignTrap}, {31'b0, exp_trap});
    bus.IGnt    = 1'b1;
    bus.IRValid = 1'b0;
    @(negedge clk);
    check("rstseq_wait_IReq", {31'b0, bus.IReq}, 32'd0);
    bus.IGnt = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rstseq_PC", PC, 32'h0);
    check("rstseq_Instr", Instr, 32'h0);
    check("rstseq_IReq", {31'b0, bus.IReq}, 32'd0);
    check("rstseq_BadAddr", BadAddr, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.IRValid = 1'b1;
    bus.IRData  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstseq_late_IReq", {31'b0, bus.IReq}, 32'd1);
    check("rstseq_late_IAddr", bus.IAddr, 32'h0);
    check("rstseq_late_InstrValid", {31'b0, InstrValid}, 32'd0);
    check("rstseq_late_Instr", Instr, 32'h0);
    bus.IRValid = 1'b0;
    $display("reset-in-WAIT sequence done");
    model_pc   = 32'h0;
    last_instr = 32'h0;
    exp_trap   = 1'b0;
    exp_bad    = 32'h0;

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      rsrc = 2'($urandom_range(0, 3));
      rtgt = $urandom;
      ralu = $urandom;
      if ($urandom_range(0, 1) == 1) rtgt = rtgt & ~32'h3;
      if ($urandom_range(0, 1) == 1) ralu = ralu & ~32'h2;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom, rsrc, rtgt, ralu);
      rnext = ref_next(model_pc, rsrc, rtgt, ralu, t);
      $display("rand %0d: pc=%h src=%b tgt=%h alu=%h next=%h trap=%0b",
               n, model_pc, rsrc, rtgt, ralu, rnext, t);
      if (t) exp_bad = (rsrc == 2'b10) ? (ralu & ~32'h1) : ((rsrc == 2'b01) ? rtgt : model_pc + 32'd4);
      exp_trap = t;
      model_pc = rnext;
    end

    // Observe the final next-PC and trap pulse
    @(negedge clk);
    check("final_IAddr", bus.IAddr, model_pc);
    check("final_trap", {31'b0, MisalignTrap}, {31'b0, exp_trap});
    check("final_BadAddr", BadAddr, exp_bad);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Sequential owner of the program counter and the producer side of the PC path. It holds `PC`, fetches the instruction at `PC` over a request/grant/response handshake, and sequences one EXEC cycle per instruction. At EXEC it loads the next PC from PC+4, the branch/JAL target, or the ALU result for JALR; the ALU result is the value the ALU SrcA/SrcB datapath computes.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on a misaligned-target trap (only with `PC_MISALIGN_TRAP_EN`).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCSrc`  in  2  next-PC select, sampled in EXEC: 2'b00 PC+4, 2'b01 PCTarget, 2'b10 ALUResult & ~32'h1, 2'b11 PC+4.
- `PCTarget`  in  32  branch/JAL target (PC+ImmExt).
- `ALUResult`  in  32  JALR target from the ALU.
- `IReq`  out  1  instruction fetch request; held until `IGnt`.
- `IAddr`  out  32  fetch address; equals `PC` while `IReq`.
- `IGnt`  in  1  memory accepted the request.
- `IRValid`  in  1  `IRData` is valid this cycle.
- `IRData`  in  32  returned instruction word.
- `Instr`  out  32  latched instruction, stable through EXEC.
- `InstrValid`  out  1  high only in EXEC.
- `PC`  out  32  current PC (the value fed to the ALU SrcA mux).
- `PCPlus4`  out  32  `PC` + 4, modulo 2^32.
- `MisalignTrap`  out  1  one-cycle pulse on a misaligned target (0 when macro is off).
- `BadAddr`  out  32  last offending target.

## Operation
- States: FETCH, WAIT, EXEC.
- FETCH: `IReq`=1, `IAddr`=`PC`. On `IGnt`: go to WAIT. If `IGnt` and `IRValid` are both high in the same cycle, latch `IRData` and go directly to EXEC.
- WAIT: `IReq`=0. On `IRValid`: latch `IRData` into `Instr` and go to EXEC. `IRValid` is ignored in FETCH unless it arrives with `IGnt`.
- EXEC: lasts exactly one cycle with `InstrValid`=1. At the clock edge, PC is loaded with the selected next PC and the state returns to FETCH.
- Next-PC arithmetic is 32-bit unsigned and wraps; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- The JALR path always clears bit 0 before any alignment check.
- `Instr` holds its value outside EXEC. It changes only when `IRData` is latched.
- Reset mid-fetch: the outstanding request is abandoned and a late `IRValid` after reset is ignored. The memory side must not return data for an abandoned request; this block provides no tag.

## Timing
- Reset values: `PC`=RESET_VECTOR, state FETCH, `IReq`=0 while `rst_n`=0, `Instr`=0, `InstrValid`=0, `MisalignTrap`=0, `BadAddr`=0.
- First `IReq` is asserted in the first cycle after `rst_n` deasserts.
- Minimum instruction period is 2 cycles (FETCH with grant and response in the same cycle, then EXEC). The typical period is 3 cycles (FETCH, WAIT, EXEC).
- `PC`, `PCPlus4` and `Instr` are stable for the whole EXEC cycle. The new PC is visible in the first FETCH cycle after EXEC.
- `MisalignTrap` is registered: it is high in the FETCH cycle after the faulting EXEC.

## Configuration
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined: if the selected target has bits [1:0] ≠ 0, PC loads TRAP_VECTOR, `BadAddr` captures the target, and `MisalignTrap` pulses for 1 cycle.
- Undefined: targets are forced word-aligned (bits [1:0] cleared). `MisalignTrap` is tied to 0 and `BadAddr` is tied to 0.

## Structure
- Package `pc_pkg` holds:
  - the state enum (FETCH, WAIT, EXEC);
  - `PCSrc` encodings (`PCSRC_PLUS4`, `PCSRC_TARGET`, `PCSRC_ALU`);
  - default vector constants.
- Sub-module `pc_next_sel`: combinational next-PC select, JALR bit-0 clear, alignment check and trap redirect. The top level holds the FSM and registers.

## Test plan
- Reset release with RESET_VECTOR=0: cycle 1 has `IReq`=1, `IAddr`=0. Grant and response with IRData=32'h00500093 → EXEC with `Instr`=32'h00500093, then next `IAddr`=4.
- `IGnt` held low for 3 cycles → `IReq` and `IAddr` remain stable for all 3 cycles; no state advance.
- PC=32'h10, PCSrc=01, PCTarget=32'h40 → next `IAddr`=32'h40. PCSrc=10, ALUResult=32'h81 → next `IAddr`=32'h80.
- PC=32'hFFFF_FFFC, PCSrc=00 → next `IAddr`=0 (wrap).
- PCSrc=01, PCTarget=32'h42:
  - macro on: `IAddr`=32'h100, `MisalignTrap` 1-cycle pulse, `BadAddr`=32'h42;
  - macro off: `IAddr`=32'h40, no pulse.
- `rst_n` asserted in WAIT → `PC` returns to RESET_VECTOR and `Instr` to 0 immediately; `IRValid` in the first post-reset cycle is ignored.
